// File: rtl/ball_pkg.sv
// Shared definitions for the ball datapath: FSM state type and playfield geometry.
// Pure declarations; no logic, no latency.
// Geometry defaults are shared with ball_pos and the renderer so all agree on the playfield.
package ball_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        LOST = 2'd2
    } ball_state_t;

    localparam int unsigned SCREEN_W  = 160;
    localparam int unsigned SCREEN_H  = 120;
    localparam int unsigned BALL_SIZE = 2;
    localparam int unsigned PADDLE_Y  = 112;
    localparam int unsigned PADDLE_W  = 16;
    localparam int unsigned SPEED_DIV = 500000;

    // Zero-extend a 10-bit coordinate so sums near 1023 cannot wrap.
    function automatic logic [10:0] ext11(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: counts 0..DIV-1 while enabled, pulses tc_o on the last count.
// tc_o is combinational from the count register (same cycle as the terminal count).
// No backpressure; clr_i holds the count at zero.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Count while enabled, wrap at the terminal value, hold at zero when cleared.
    always_ff @(posedge clk) begin
        if (!resetn || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tc_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ball_dir_ctrl.sv
// Ball direction control: wall/paddle/brick bounces, bottom loss detection, step enable.
// Direction updated in the terminal-count cycle (A); move_en pulses one cycle later (A+1).
// No backpressure; brick_hit is latched sticky and consumed at the next cycle A.
module ball_dir_ctrl
    import ball_pkg::*;
#(
    parameter int unsigned SCREEN_W  = ball_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H  = ball_pkg::SCREEN_H,
    parameter int unsigned BALL_SIZE = ball_pkg::BALL_SIZE,
    parameter int unsigned PADDLE_Y  = ball_pkg::PADDLE_Y,
    parameter int unsigned PADDLE_W  = ball_pkg::PADDLE_W,
    parameter int unsigned SPEED_DIV = ball_pkg::SPEED_DIV
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       launch,
    input  logic       brick_hit,
    input  logic [9:0] paddle_x,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       move_en,
    output logic       x_du,
    output logic       y_du,
    output logic       ball_lost,
    output logic       in_play
);

    localparam logic [10:0] RIGHT_LIM = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] BOT_LIM   = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] BS11      = 11'(BALL_SIZE);
    localparam logic [10:0] PY11      = 11'(PADDLE_Y);
    localparam logic [10:0] PW11      = 11'(PADDLE_W);

    ball_state_t state_q;
    logic        x_du_q, y_du_q;
    logic        x_du_d, y_du_d;
    logic        move_en_q, ball_lost_q, in_play_q;
    logic        brick_q;
    logic        tick_a;
    logic        bottom;
    logic        hit_paddle;

    logic [10:0] x11, y11, px11;
    assign x11  = ext11(x);
    assign y11  = ext11(y);
    assign px11 = ext11(paddle_x);

    // Divider only runs in MOVE; held at zero elsewhere so launch restarts it cleanly.
    tick_gen #(
        .DIV (SPEED_DIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (state_q != MOVE),
        .en_i   (state_q == MOVE),
        .tc_o   (tick_a)
    );

    // Collision evaluation on the current position; results only used in cycle A.
    always_comb begin
        logic hit_left, hit_right, hit_top, brick_eff;
        hit_left   = (x11 == 11'd0) && !x_du_q;
        hit_right  = (x11 >= RIGHT_LIM) && x_du_q;
        hit_top    = (y11 == 11'd0) && !y_du_q;
        hit_paddle = y_du_q && ((y11 + BS11) == PY11)
                     && ((x11 + BS11) > px11) && (x11 < (px11 + PW11));
        // A brick pulse arriving in cycle A itself still counts.
        brick_eff  = brick_q || brick_hit;
        bottom     = y_du_q && (y11 >= BOT_LIM);

        x_du_d = x_du_q;
        if (hit_left) begin
            x_du_d = 1'b1;
        end else if (hit_right) begin
            x_du_d = 1'b0;
        end

        // Paddle wins over brick; top wall already points down so a brick flip agrees.
        y_du_d = y_du_q;
        if (hit_top) begin
            y_du_d = 1'b1;
        end else if (hit_paddle) begin
            y_du_d = 1'b0;
        end else if (brick_eff) begin
            y_du_d = ~y_du_q;
        end
    end

    // Game FSM with registered outputs; move_en is the cycle-A tick delayed by one flop.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            x_du_q      <= 1'b1;
            y_du_q      <= 1'b0;
            move_en_q   <= 1'b0;
            ball_lost_q <= 1'b0;
            in_play_q   <= 1'b0;
            brick_q     <= 1'b0;
        end else begin
            move_en_q   <= 1'b0;
            ball_lost_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_q   <= MOVE;
                        x_du_q    <= 1'b1;
                        y_du_q    <= 1'b0;
                        in_play_q <= 1'b1;
                        brick_q   <= 1'b0;
                    end
                end
                MOVE: begin
                    if (tick_a) begin
                        brick_q <= 1'b0;
                        if (bottom) begin
                            // Ball is gone: hold directions, no step.
                            state_q     <= LOST;
                            in_play_q   <= 1'b0;
                            ball_lost_q <= 1'b1;
                        end else begin
                            x_du_q    <= x_du_d;
                            y_du_q    <= y_du_d;
                            move_en_q <= 1'b1;
                        end
                    end else if (brick_hit) begin
                        brick_q <= 1'b1;
                    end
                end
                LOST: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign move_en   = move_en_q;
    assign x_du      = x_du_q;
    assign y_du      = y_du_q;
    assign ball_lost = ball_lost_q;
    assign in_play   = in_play_q;

endmodule

// File: tb/tb_ball_dir_ctrl.sv
// Directed bench for ball_dir_ctrl with a 4-cycle step divider.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Each step advances one clock.
module tb_ball_dir_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       launch;
    logic       brick_hit;
    logic [9:0] paddle_x;
    logic [9:0] x;
    logic [9:0] y;
    logic       move_en, x_du, y_du, ball_lost, in_play;

    int checks = 0;
    int errors = 0;

    ball_dir_ctrl #(
        .SCREEN_W  (160),
        .SCREEN_H  (120),
        .BALL_SIZE (2),
        .PADDLE_Y  (112),
        .PADDLE_W  (16),
        .SPEED_DIV (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .launch    (launch),
        .brick_hit (brick_hit),
        .paddle_x  (paddle_x),
        .x         (x),
        .y         (y),
        .move_en   (move_en),
        .x_du      (x_du),
        .y_du      (y_du),
        .ball_lost (ball_lost),
        .in_play   (in_play)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Step until move_en is seen, bounded; returns the number of steps taken.
    task automatic next_move(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!move_en && n < 16);
    endtask

    initial begin
        int  n;
        logic seen;

        resetn    = 1'b0;
        launch    = 1'b0;
        brick_hit = 1'b0;
        paddle_x  = 10'd40;
        x         = 10'd50;
        y         = 10'd60;
        step();
        step();
        check("rst_x_du", x_du, 1);
        check("rst_y_du", y_du, 0);
        check("rst_move_en", move_en, 0);
        check("rst_ball_lost", ball_lost, 0);
        check("rst_in_play", in_play, 0);
        resetn = 1'b1;
        step();
        check("idle_hold", in_play, 0);

        // 1. Launch and step cadence
        launch = 1'b1;
        step();
        launch = 1'b0;
        check("launch_in_play", in_play, 1);
        check("launch_x_du", x_du, 1);
        check("launch_y_du", y_du, 0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen = seen | move_en;
            step();
        end
        check("no_early_move", seen, 0);
        step();
        check("first_move", move_en, 1);
        next_move(n);
        check("move_period", n, 4);

        // 2. Right wall: no change before cycle A, flip lands with the move
        x = 10'd158;
        step(); step(); step();
        check("right_wall_pre", x_du, 1);
        step();
        check("right_wall_move", move_en, 1);
        check("right_wall_x_du", x_du, 0);

        // launch ignored during MOVE: no reload, divider not restarted
        launch = 1'b1;
        step();
        launch = 1'b0;
        x = 10'd50;
        check("launch_ign_x_du", x_du, 0);
        next_move(n);
        check("launch_ign_period", n, 3);
        check("launch_ign_x_du2", x_du, 0);

        // 3. Corner (left + top)
        x = 10'd0;
        y = 10'd0;
        next_move(n);
        check("corner_period", n, 4);
        check("corner_x_du", x_du, 1);
        check("corner_y_du", y_du, 1);

        // 4. Paddle hit, paddle miss at right edge, paddle beats brick
        x = 10'd55;
        y = 10'd110;
        next_move(n);
        check("paddle_y_du", y_du, 0);
        check("paddle_x_du", x_du, 1);
        x = 10'd50;
        y = 10'd0;
        next_move(n);
        check("top_y_du", y_du, 1);
        x = 10'd56;
        y = 10'd110;
        next_move(n);
        check("paddle_miss_y_du", y_du, 1);
        x = 10'd55;
        step();
        brick_hit = 1'b1;
        step();
        brick_hit = 1'b0;
        next_move(n);
        check("paddle_brick_y_du", y_du, 0);
        x = 10'd50;
        y = 10'd60;
        next_move(n);
        check("brick_latch_clr", y_du, 0);

        // 5. Brick flip only at cycle A, and only once
        step();
        brick_hit = 1'b1;
        step();
        brick_hit = 1'b0;
        step();
        check("brick_no_early", y_du, 0);
        step();
        check("brick_move", move_en, 1);
        check("brick_flip", y_du, 1);
        next_move(n);
        check("brick_once", y_du, 1);
        brick_hit = 1'b1;
        step();
        brick_hit = 1'b0;
        step();
        brick_hit = 1'b1;
        step();
        brick_hit = 1'b0;
        step();
        check("dbl_brick_move", move_en, 1);
        check("dbl_brick_flip", y_du, 0);
        next_move(n);
        check("dbl_brick_once", y_du, 0);

        // Mid-MOVE reset right before a step would be issued
        y = 10'd0;
        next_move(n);
        x = 10'd158;
        y = 10'd60;
        next_move(n);
        check("pre_rst_x_du", x_du, 0);
        check("pre_rst_y_du", y_du, 1);
        x = 10'd50;
        step(); step(); step();
        resetn = 1'b0;
        step();
        check("midrst_move_en", move_en, 0);
        check("midrst_x_du", x_du, 1);
        check("midrst_y_du", y_du, 0);
        check("midrst_in_play", in_play, 0);
        check("midrst_ball_lost", ball_lost, 0);
        resetn = 1'b1;
        step();
        check("midrst_idle", in_play, 0);

        // 6. Bottom loss
        launch = 1'b1;
        step();
        launch = 1'b0;
        y = 10'd0;
        next_move(n);
        check("relaunch_period", n, 4);
        check("bottom_pre_y_du", y_du, 1);
        y = 10'd118;
        step(); step(); step();
        step();
        check("bottom_no_move", move_en, 0);
        check("bottom_lost", ball_lost, 1);
        check("bottom_in_play", in_play, 0);
        step();
        check("lost_one_cycle", ball_lost, 0);
        check("lost_x_du_held", x_du, 1);
        check("lost_y_du_held", y_du, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | move_en | in_play | ball_lost;
        end
        check("idle_quiet", seen, 0);
        launch = 1'b1;
        step();
        launch = 1'b0;
        check("post_lost_launch", in_play, 1);
        check("post_lost_y_du", y_du, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
